// File: rtl/param_counter.sv
// param_counter: parametrised up/down counter with prescaler, load, modulus,
// wrap/saturate modes, terminal-count pulse and sticky overflow flag.
module param_counter #(
  parameter int WIDTH = 4,
  parameter int PRESCALE = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);
  logic tick;
  logic at_top, at_bot, over, bnd;
  logic [WIDTH-1:0] nxt;
  generate
    if (PRESCALE > 1) begin : g_psc
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] psc;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) psc <= '0;
        else if (load) psc <= '0;
        else if (en) psc <= (psc == PW'(PRESCALE - 1)) ? '0 : psc + 1'b1;
      assign tick = en && !load && psc == PW'(PRESCALE - 1);
    end else begin : g_nopsc
      assign tick = en && !load;
    end
  endgenerate
  always_comb begin
    at_top = out >= mod_val;
    at_bot = out == '0;
    over   = out > mod_val;
    bnd    = tick && (up_dn ? at_top : at_bot);
    // a lowered modulus pulls a down-count back into range without a boundary event
    nxt = load ? ((load_val > mod_val) ? mod_val : load_val)
        : !tick ? out
        : up_dn ? (at_top ? (sat_mode ? mod_val : '0) : out + 1'b1)
        : over ? mod_val
        : at_bot ? (sat_mode ? '0 : mod_val)
        : out - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out <= WIDTH'(RESET_VAL);
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out <= nxt;
      tc  <= bnd;
      ovf <= bnd | (ovf & ~clr_ovf);
    end
endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed and randomized checks of two param_counter
// instances (PRESCALE 1 and 3) against a behavioural model.
module tb_param_counter;
  logic clk = 0, rst_n = 0;
  logic en = 1, up_dn = 1, load = 0, sat_mode = 0, clr_ovf = 0;
  logic [3:0] load_val = 0, mod_val = 15;
  logic [3:0] out1, out3;
  logic tc1, tc3, ovf1, ovf3;
  int total = 0, bad = 0;
  localparam int P[2]  = '{1, 3};
  localparam int RV[2] = '{0, 3};
  int m_out[2], m_psc[2];
  bit m_tc[2], m_ovf[2];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .PRESCALE(1), .RESET_VAL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_val(mod_val), .sat_mode(sat_mode),
    .clr_ovf(clr_ovf), .out(out1), .tc(tc1), .ovf(ovf1));
  param_counter #(.WIDTH(4), .PRESCALE(3), .RESET_VAL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_val(mod_val), .sat_mode(sat_mode),
    .clr_ovf(clr_ovf), .out(out3), .tc(tc3), .ovf(ovf3));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = RV[i]; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // counts are plain integers in 0..mod_val; a boundary is stepping past either end
  task automatic model_step();
    int mv, lv;
    bit b;
    mv = int'(mod_val);
    lv = int'(load_val);
    for (int i = 0; i < 2; i++) begin
      b = 0;
      if (load) begin
        m_out[i] = (lv < mv) ? lv : mv;
        m_psc[i] = 0;
      end else if (en) begin
        m_psc[i]++;
        if (m_psc[i] == P[i]) begin
          m_psc[i] = 0;
          if (up_dn) begin
            if (m_out[i] < mv) m_out[i]++;
            else begin m_out[i] = sat_mode ? mv : 0; b = 1; end
          end else begin
            if (m_out[i] > mv) m_out[i] = mv;
            else if (m_out[i] > 0) m_out[i]--;
            else begin m_out[i] = sat_mode ? 0 : mv; b = 1; end
          end
        end
      end
      m_tc[i] = b;
      m_ovf[i] = b || (m_ovf[i] && !clr_ovf);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".out1"}, out1, m_out[0]);
    check({tag, ".tc1"},  tc1,  m_tc[0]);
    check({tag, ".ovf1"}, ovf1, m_ovf[0]);
    check({tag, ".out3"}, out3, m_out[1]);
    check({tag, ".tc3"},  tc3,  m_tc[1]);
    check({tag, ".ovf3"}, ovf3, m_ovf[1]);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    model_reset();
    #10;
    check("rst.out1", out1, 0);
    check("rst.out3", out3, 3);
    check("rst.tc1", tc1, 0);
    check("rst.ovf1", ovf1, 0);
    #10 rst_n = 1;
    repeat (5) cycle("count5");
    check("count5.out", out1, 5);
    check("count5.tc", tc1, 0);
    check("count5.ovf", ovf1, 0);

    // wrap at mod_val=9
    mod_val = 9; load_val = 0; load = 1;
    cycle("wrap.load");
    load = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle("wrap");
      check("wrap.tc", tc1, k == 10);
    end
    check("wrap.out", out1, 0);
    check("wrap.ovf", ovf1, 1);
    en = 0; clr_ovf = 1;
    cycle("clr");
    clr_ovf = 0;
    check("clr.ovf", ovf1, 0);

    // saturating down-count from 2
    en = 1; sat_mode = 1; load_val = 2; load = 1;
    cycle("sat.load");
    load = 0; up_dn = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle("sat");
      check("sat.out", out1, (k == 1) ? 1 : 0);
      check("sat.tc", tc1, k >= 3);
    end
    check("sat.ovf", ovf1, 1);

    // load over enable, then set beats clear
    sat_mode = 0; up_dn = 1; load = 1; load_val = 12; mod_val = 10;
    cycle("ldp");
    check("ldp.out", out1, 10);
    check("ldp.tc", tc1, 0);
    load = 0; clr_ovf = 1;
    cycle("setclr");
    clr_ovf = 0;
    check("setclr.out", out1, 0);
    check("setclr.ovf", ovf1, 1);

    // prescaler with an en gap mid-period
    mod_val = 15; load_val = 0; load = 1;
    cycle("psc.load");
    load = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle("psc");
      check("psc.out3", out3, k / 3);
    end
    en = 0;
    repeat (2) cycle("psc.gap");
    check("psc.gap.out3", out3, 1);
    en = 1;
    cycle("psc.e7");
    check("psc.e7.out3", out3, 1);
    cycle("psc.e8");
    check("psc.e8.out3", out3, 2);

    // asynchronous reset between edges
    load_val = 7; load = 1;
    cycle("mid.load");
    load = 0; en = 0;
    check("mid.pre", out1, 7);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("mid.out1", out1, 0);
    check("mid.out3", out3, 3);
    check("mid.ovf1", ovf1, 0);
    #2 rst_n = 1;
    en = 1;
    cycle("mid.tick");
    check("mid.tick.out1", out1, 1);

    // randomized
    for (int n = 0; n < 400; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1);
      load     = ($urandom_range(0, 7) == 0);
      load_val = 4'($urandom);
      mod_val  = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom);
      sat_mode = $urandom_range(0, 1);
      clr_ovf  = !load && ($urandom_range(0, 5) == 0);
      cycle("rand");
    end

    $display(bad == 0 ? "TEST PASSED" : "TEST FAILED");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
